// File: rtl/argmax_stream_source_pkg.sv
// Shared types and constants for the argmax ping-pong stream source.
//   bank_state_e   : per-bank fill state (EMPTY / FILLING / FULL)
//   stream_state_e : streamer FSM state (IDLE / STREAM)
//   addr_width()   : address width derived from the number of cells per vector
package argmax_pkg;

   typedef enum logic [1:0] {
      BankEmpty   = 2'd0,
      BankFilling = 2'd1,
      BankFull    = 2'd2
   } bank_state_e;

   typedef enum logic {
      StIdle   = 1'b0,
      StStream = 1'b1
   } stream_state_e;

   localparam int unsigned CellAmountDefault = 4;

   // Width of a cell address; never below one bit.
   function automatic int unsigned addr_width(input int unsigned cells);
      return (cells > 1) ? $clog2(cells) : 1;
   endfunction

endpackage

// File: rtl/argmax_stream_source_if.sv
// Value-in / indexed-stream-out bus of the argmax stream source.
//   input_value/input_valid/input_ready : upstream valid/ready word transfer
//   output_index/output_value           : streamed element and its position
//   output_enable                       : stream word valid (no backpressure)
//   output_busy                         : data buffered or streaming
// slave is the block's view, master the surrounding logic's view.
interface argmax_stream_source_if #(
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic [DATA_WIDTH-1:0] input_value;
   logic                  input_valid;
   logic                  input_ready;
   logic [DATA_WIDTH-1:0] output_index;
   logic [DATA_WIDTH-1:0] output_value;
   logic                  output_enable;
   logic                  output_busy;

   modport master (
      output input_value,
      output input_valid,
      input  input_ready,
      input  output_index,
      input  output_value,
      input  output_enable,
      input  output_busy
   );

   modport slave (
      input  input_value,
      input  input_valid,
      output input_ready,
      output output_index,
      output output_value,
      output output_enable,
      output output_busy
   );

endinterface

// File: rtl/argmax_bank.sv
// One vector bank: CELL_AMOUNT x DATA_WIDTH storage with its fill state.
//   clk, reset_n : clock, asynchronous active-low reset (state only, not memory)
//   wr_en/wr_data: write next cell in acceptance order (caller keeps off while FULL)
//   free_en      : return the bank to EMPTY once it has been streamed
//   rd_addr      : combinational read address, rd_data the addressed word
//   state        : EMPTY / FILLING / FULL
//   wr_last      : the current write fills the final cell
module argmax_bank
   import argmax_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned CELL_AMOUNT = CellAmountDefault
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               wr_en,
   input  logic [DATA_WIDTH-1:0]              wr_data,
   input  logic                               free_en,
   input  logic [addr_width(CELL_AMOUNT)-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0]              rd_data,
   output bank_state_e                        state,
   output logic                               wr_last
);

   localparam int unsigned          AddrWidth = addr_width(CELL_AMOUNT);
   localparam logic [AddrWidth-1:0] LastAddr  = AddrWidth'(CELL_AMOUNT - 1);

   logic [DATA_WIDTH-1:0] mem_q [CELL_AMOUNT];
   logic [AddrWidth-1:0]  wr_addr_q, wr_addr_d;
   bank_state_e           state_q, state_d;

   assign wr_last = wr_en && (wr_addr_q == LastAddr);
   assign rd_data = mem_q[rd_addr];
   assign state   = state_q;

   always_comb begin
      state_d   = state_q;
      wr_addr_d = wr_addr_q;
      if (free_en) begin
         state_d   = BankEmpty;
         wr_addr_d = '0;
      end else if (wr_en) begin
         if (wr_last) begin
            state_d   = BankFull;
            wr_addr_d = '0;
         end else begin
            state_d   = BankFilling;
            wr_addr_d = wr_addr_q + AddrWidth'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= BankEmpty;
         wr_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_addr_q <= wr_addr_d;
      end
   end

   // Storage is deliberately left unreset; a bank is only read once FULL.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/argmax_stream_source.sv
// Ping-pong vector buffer feeding an argmax stage: words are collected into
// two banks of CELL_AMOUNT cells and every complete bank is streamed out as
// (index, value) pairs, one per cycle, in fill order.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : input_value/valid/ready in, output_index/value/enable/busy out
module argmax_stream_source
   import argmax_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned CELL_AMOUNT = CellAmountDefault
) (
   input  logic                         clk,
   input  logic                         reset_n,
   argmax_stream_source_if.slave        bus
);

   localparam int unsigned          AddrWidth = addr_width(CELL_AMOUNT);
   localparam logic [AddrWidth-1:0] LastAddr  = AddrWidth'(CELL_AMOUNT - 1);

   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   stream_state_e         state_q, state_d;
   logic [AddrWidth-1:0]  rd_idx_q, rd_idx_d;

   logic [1:0]            bank_wr_en;
   logic [1:0]            bank_free;
   logic [1:0]            bank_full;
   logic [1:0]            bank_used;
   logic [1:0]            bank_wr_last;
   logic [DATA_WIDTH-1:0] bank_rd_data [2];
   bank_state_e           bank_state   [2];

   logic                  accept;
   logic                  write_done;
   logic                  other_ready;

   logic                  out_enable_q, out_enable_d;
   logic                  out_busy_q, out_busy_d;
   logic [DATA_WIDTH-1:0] out_index_q, out_index_d;
   logic [DATA_WIDTH-1:0] out_value_q, out_value_d;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      argmax_bank #(
         .DATA_WIDTH  (DATA_WIDTH),
         .CELL_AMOUNT (CELL_AMOUNT)
      ) u_bank (
         .clk     (clk),
         .reset_n (reset_n),
         .wr_en   (bank_wr_en[b]),
         .wr_data (bus.input_value),
         .free_en (bank_free[b]),
         .rd_addr (rd_idx_q),
         .rd_data (bank_rd_data[b]),
         .state   (bank_state[b]),
         .wr_last (bank_wr_last[b])
      );

      assign bank_full[b]  = (bank_state[b] == BankFull);
      assign bank_used[b]  = (bank_state[b] != BankEmpty);
      assign bank_wr_en[b] = accept && (int'(wr_ptr_q) == b);
   end

   // Ready looks only at registered bank state, never at input_valid.
   assign bus.input_ready = !bank_full[wr_ptr_q];
   assign accept          = bus.input_valid && bus.input_ready;
   assign write_done      = accept && bank_wr_last[wr_ptr_q];
   assign wr_ptr_d        = wr_ptr_q ^ write_done;

   // The other bank is FULL now or completes on this very edge; looking at the
   // completing write keeps the stream gap-free when both finish together.
   assign other_ready = bank_full[~rd_ptr_q] || (write_done && (wr_ptr_q != rd_ptr_q));

   always_comb begin
      state_d   = state_q;
      rd_ptr_d  = rd_ptr_q;
      rd_idx_d  = rd_idx_q;
      bank_free = '0;
      case (state_q)
         StIdle: begin
            if (bank_full[rd_ptr_q]) begin
               state_d  = StStream;
               rd_idx_d = '0;
            end
         end
         StStream: begin
            if (rd_idx_q == LastAddr) begin
               bank_free[rd_ptr_q] = 1'b1;
               rd_ptr_d            = ~rd_ptr_q;
               rd_idx_d            = '0;
               if (!other_ready) begin
                  state_d = StIdle;
               end
            end else begin
               rd_idx_d = rd_idx_q + AddrWidth'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output stage: the word addressed this cycle is presented after the edge.
   always_comb begin
      out_enable_d = (state_q == StStream);
      out_index_d  = '0;
      out_value_d  = '0;
      if (out_enable_d) begin
         out_index_d = DATA_WIDTH'(rd_idx_q);
         out_value_d = bank_rd_data[rd_ptr_q];
      end
      out_busy_d = bank_used[0] || bank_used[1] || accept || (state_q == StStream);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         state_q      <= StIdle;
         rd_idx_q     <= '0;
         out_enable_q <= 1'b0;
         out_busy_q   <= 1'b0;
         out_index_q  <= '0;
         out_value_q  <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         state_q      <= state_d;
         rd_idx_q     <= rd_idx_d;
         out_enable_q <= out_enable_d;
         out_busy_q   <= out_busy_d;
         out_index_q  <= out_index_d;
         out_value_q  <= out_value_d;
      end
   end

   assign bus.output_enable = out_enable_q;
   assign bus.output_busy   = out_busy_q;
   assign bus.output_index  = out_index_q;
   assign bus.output_value  = out_value_q;

endmodule

// File: tb/tb_argmax_stream_source.sv
// Bench for argmax_stream_source (DATA_WIDTH 32, CELL_AMOUNT 4). A monitor logs
// every emitted word with its cycle number; the reference model is the list of
// accepted words, of which only complete groups of four are expected back, in
// order, with indices 0..3.
module tb_argmax_stream_source;

   localparam int unsigned Dw    = 32;
   localparam int unsigned Cells = 4;

   typedef struct packed {
      int unsigned cyc;
      logic [31:0] idx;
      logic [31:0] val;
   } emit_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   argmax_stream_source_if #(.DATA_WIDTH(Dw)) bus ();

   argmax_stream_source #(
      .DATA_WIDTH  (Dw),
      .CELL_AMOUNT (Cells)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int unsigned checks   = 0;
   int unsigned failures = 0;
   int unsigned cyc      = 0;
   int unsigned ready_low;
   logic [31:0] sent[$];
   int unsigned acc_cyc[$];
   emit_t       got[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.output_enable) got.push_back('{cyc, bus.output_index, bus.output_value});
      if (!bus.input_ready) ready_low++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Offer v with valid held high until accepted (bounded).
   task automatic push_word(input logic [31:0] v);
      int unsigned tries = 0;
      logic        acc   = 1'b0;
      int unsigned dcyc  = 0;
      while (!acc && tries < 64) begin
         @(negedge clk);
         bus.input_valid = 1'b1;
         bus.input_value = v;
         acc  = bus.input_ready;
         dcyc = cyc;
         @(posedge clk);
         tries++;
      end
      if (acc) begin
         sent.push_back(v);
         acc_cyc.push_back(dcyc + 1);
      end else begin
         chk("accept_timeout", 32'(acc), 32'(1));
      end
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      bus.input_valid = 1'b0;
      @(posedge clk);
   endtask

   task automatic wait_idle(input string tag);
      int unsigned n = 0;
      @(negedge clk);
      bus.input_valid = 1'b0;
      while (bus.output_busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle"}, 32'(bus.output_busy), 32'(0));
   endtask

   task automatic check_stream(input string tag);
      int unsigned n = (sent.size() / Cells) * Cells;
      chk({tag, "_count"}, 32'(got.size()), 32'(n));
      for (int k = 0; k < got.size() && k < n; k++) begin
         chk({tag, "_idx"}, got[k].idx, 32'(k % Cells));
         chk({tag, "_val"}, got[k].val, sent[k]);
      end
   endtask

   // First word two edges after the accepting edge, then no gaps.
   task automatic check_timing(input string tag, input int unsigned first_acc);
      int unsigned gaps = 0;
      if (got.size() == 0) begin
         chk({tag, "_lat"}, 32'(0), 32'(first_acc + 2));
      end else begin
         chk({tag, "_lat"}, 32'(got[0].cyc), 32'(first_acc + 2));
         for (int k = 1; k < got.size(); k++) begin
            if (got[k].cyc != got[k-1].cyc + 1) gaps++;
         end
         chk({tag, "_gaps"}, 32'(gaps), 32'(0));
      end
   endtask

   task automatic clear_model();
      sent.delete();
      acc_cyc.delete();
      got.delete();
      ready_low = 0;
   endtask

   initial begin
      int unsigned exp_am;
      int unsigned obs_am;
      int unsigned gap;
      logic [31:0] vec [4];

      reset_n         = 1'b0;
      bus.input_valid = 1'b0;
      bus.input_value = '0;
      ready_low       = 0;

      // Reset state
      #1;
      chk("rst_enable", 32'(bus.output_enable), 32'(0));
      chk("rst_index", bus.output_index, 32'(0));
      chk("rst_value", bus.output_value, 32'(0));
      chk("rst_busy", 32'(bus.output_busy), 32'(0));
      chk("rst_ready", 32'(bus.input_ready), 32'(1));
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      clear_model();

      // Single vector 5,9,2,7 and its argmax
      vec[0] = 32'd5; vec[1] = 32'd9; vec[2] = 32'd2; vec[3] = 32'd7;
      for (int i = 0; i < 4; i++) push_word(vec[i]);
      wait_idle("r028");
      check_stream("r028");
      check_timing("r028", acc_cyc[3]);
      exp_am = 0;
      for (int k = 1; k < 4; k++) if (sent[k] > sent[exp_am]) exp_am = k;
      obs_am = 0;
      if (got.size() >= 4) begin
         for (int k = 1; k < 4; k++) if (got[k].val > got[obs_am].val) obs_am = k;
      end
      chk("r028_argmax", 32'(obs_am), 32'(exp_am));
      clear_model();

      // Eight words back to back
      for (int i = 0; i < 8; i++) push_word(32'h100 + 32'(i));
      wait_idle("r029");
      check_stream("r029");
      check_timing("r029", acc_cyc[3]);
      clear_model();

      // Twelve words back to back: ready must stall while both banks are FULL
      for (int i = 0; i < 12; i++) push_word(32'h200 + 32'(i * 3));
      wait_idle("r030");
      check_stream("r030");
      chk("r030_stalled", 32'(ready_low > 0), 32'(1));
      chk("r030_ready_end", 32'(bus.input_ready), 32'(1));
      clear_model();

      // Last write of the second bank on the same edge as the last index of the first
      for (int i = 0; i < 7; i++) push_word(32'h300 + 32'(i));
      idle_cycle();
      push_word(32'h307);
      wait_idle("r032");
      check_stream("r032");
      check_timing("r032", acc_cyc[3]);
      clear_model();

      // Sparse writes
      for (int i = 0; i < 4; i++) begin
         push_word(32'h400 + 32'(i));
         idle_cycle();
      end
      wait_idle("r033");
      check_stream("r033");
      check_timing("r033", acc_cyc[3]);
      clear_model();

      // Reset in the middle of a stream with a partial second vector
      for (int i = 0; i < 7; i++) push_word(32'h500 + 32'(i));
      @(negedge clk);
      bus.input_valid = 1'b0;
      chk("r031_pre_enable", 32'(bus.output_enable), 32'(1));
      #2 reset_n = 1'b0;
      #1;
      chk("r031_enable", 32'(bus.output_enable), 32'(0));
      chk("r031_index", bus.output_index, 32'(0));
      chk("r031_value", bus.output_value, 32'(0));
      chk("r031_busy", 32'(bus.output_busy), 32'(0));
      clear_model();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("r031_no_emit", 32'(got.size()), 32'(0));
      chk("r031_ready", 32'(bus.input_ready), 32'(1));
      chk("r031_busy_after", 32'(bus.output_busy), 32'(0));
      for (int i = 0; i < 4; i++) push_word(32'h600 + 32'(i));
      wait_idle("r031_new");
      check_stream("r031_new");
      clear_model();

      // Randomized traffic: five vectors with random idle gaps
      for (int v = 0; v < 5; v++) begin
         for (int w = 0; w < 4; w++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) idle_cycle();
            push_word($urandom);
         end
      end
      wait_idle("rand");
      check_stream("rand");
      clear_model();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
